// File: rtl/usb_rx_unstuff.sv
// USB full-speed receive front end: NRZI decode, SYNC/EOP detection, bit unstuffing, byte assembly.
// Every output is registered one cycle after its line sample; no backpressure, one sample is consumed per clock.
module usb_rx_unstuff (
  input  logic       clk,
  input  logic       rst_L,
  input  logic       dp,
  input  logic       dm,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic       rx_active,
  output logic       rx_err
);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ABORT} state_t;

  state_t     state, state_nx;
  logic       is_j, is_k, is_se0, is_se1, bit_dec;
  logic       prev_j, prev_j_nx;
  logic [2:0] zero_cnt, zero_nx;
  logic [2:0] ones_cnt, ones_nx;
  logic [2:0] bit_cnt, bit_nx;
  logic [2:0] j_cnt, j_nx;
  logic [7:0] shreg, shreg_nx, byte_nx;
  logic       pkt_err, pkt_err_nx;
  logic       bv_nx, ps_nx, pe_nx, act_nx, err_nx;

  assign is_j    = dp & ~dm;
  assign is_k    = ~dp & dm;
  assign is_se0  = ~dp & ~dm;
  assign is_se1  = dp & dm;
  // Same symbol as last bit time decodes to 1; only meaningful for J/K.
  assign bit_dec = (is_j == prev_j);
  assign prev_j_nx = is_j | is_se0 | is_se1;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (is_k) state_nx = SYNC;
      SYNC: begin
        if (is_se0 || is_se1)   state_nx = IDLE;
        else if (bit_dec)       state_nx = (zero_cnt >= 3'd6) ? DATA : IDLE;
      end
      DATA: begin
        if (is_se0)                           state_nx = EOP;
        else if (is_se1)                      state_nx = ABORT;
        else if (ones_cnt == 3'd6 && bit_dec) state_nx = ABORT;
      end
      EOP: begin
        if (is_j)         state_nx = IDLE;
        else if (!is_se0) state_nx = ABORT;
      end
      ABORT: if (is_j && j_cnt == 3'd6) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    zero_nx    = zero_cnt;
    ones_nx    = ones_cnt;
    bit_nx     = bit_cnt;
    j_nx       = 3'd0;
    shreg_nx   = shreg;
    byte_nx    = byte_out;
    pkt_err_nx = pkt_err;
    bv_nx      = 1'b0;
    ps_nx      = 1'b0;
    pe_nx      = 1'b0;
    err_nx     = 1'b0;
    act_nx     = (state_nx == DATA) || (state_nx == EOP);
    case (state)
      IDLE: if (is_k) zero_nx = 3'd1;
      SYNC: begin
        if (is_j || is_k) begin
          if (!bit_dec) begin
            if (zero_cnt != 3'd7) zero_nx = zero_cnt + 3'd1;
          end else if (zero_cnt >= 3'd6) begin
            // The closing 1 of SYNC already counts toward the stuffing run.
            ps_nx      = 1'b1;
            ones_nx    = 3'd1;
            bit_nx     = 3'd0;
            shreg_nx   = 8'd0;
            pkt_err_nx = 1'b0;
          end
        end
      end
      DATA: begin
        if (is_se0) begin
          if (bit_cnt != 3'd0) begin
            err_nx     = 1'b1;
            pkt_err_nx = 1'b1;
          end
          bit_nx   = 3'd0;
          shreg_nx = 8'd0;
        end else if (is_se1) begin
          err_nx = 1'b1;
        end else if (ones_cnt == 3'd6) begin
          if (bit_dec) err_nx  = 1'b1;
          else         ones_nx = 3'd0;
        end else begin
          shreg_nx[bit_cnt] = bit_dec;
          bit_nx  = bit_cnt + 3'd1;
          ones_nx = bit_dec ? ones_cnt + 3'd1 : 3'd0;
          if (bit_cnt == 3'd7) begin
            byte_nx = {bit_dec, shreg[6:0]};
            bv_nx   = 1'b1;
          end
        end
      end
      EOP: begin
        if (is_j)         pe_nx  = ~pkt_err;
        else if (!is_se0) err_nx = 1'b1;
      end
      ABORT: if (is_j && j_cnt != 3'd6) j_nx = j_cnt + 3'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      prev_j     <= 1'b1;
      zero_cnt   <= 3'd0;
      ones_cnt   <= 3'd0;
      bit_cnt    <= 3'd0;
      j_cnt      <= 3'd0;
      shreg      <= 8'd0;
      pkt_err    <= 1'b0;
      byte_out   <= 8'd0;
      byte_valid <= 1'b0;
      pkt_start  <= 1'b0;
      pkt_end    <= 1'b0;
      rx_active  <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      prev_j     <= prev_j_nx;
      zero_cnt   <= zero_nx;
      ones_cnt   <= ones_nx;
      bit_cnt    <= bit_nx;
      j_cnt      <= j_nx;
      shreg      <= shreg_nx;
      pkt_err    <= pkt_err_nx;
      byte_out   <= byte_nx;
      byte_valid <= bv_nx;
      pkt_start  <= ps_nx;
      pkt_end    <= pe_nx;
      rx_active  <= act_nx;
      rx_err     <= err_nx;
    end
  end

endmodule

// File: tb/tb_usb_rx_unstuff.sv
// Drives line-symbol streams built by a packet-level encoder and checks every output cycle by cycle.
module tb_usb_rx_unstuff;
  logic       clk = 1'b0;
  logic       rst_L = 1'b0;
  logic       dp = 1'b1;
  logic       dm = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid, pkt_start, pkt_end, rx_active, rx_err;
  int         total = 0;
  int         bad = 0;

  usb_rx_unstuff dut (
    .clk(clk), .rst_L(rst_L), .dp(dp), .dm(dm),
    .byte_out(byte_out), .byte_valid(byte_valid), .pkt_start(pkt_start),
    .pkt_end(pkt_end), .rx_active(rx_active), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] SJ = 2'b10, SK = 2'b01, S0 = 2'b00;

  // Expected word per sample: {byte_valid, pkt_start, pkt_end, rx_active, rx_err, byte_out}
  logic [1:0]  sym_q[$];
  logic [12:0] exp_q[$];
  logic [12:0] obs_q[$];
  logic        lvl = 1'b1;
  logic        act = 1'b0;
  logic [7:0]  ebo = 8'd0;
  int          run = 0;

  function automatic logic [12:0] outs_now();
    return {byte_valid, pkt_start, pkt_end, rx_active, rx_err, byte_out};
  endfunction

  task automatic push(input logic [1:0] s, input logic bv, input logic ps, input logic pe, input logic er);
    sym_q.push_back(s);
    exp_q.push_back({bv, ps, pe, act, er, ebo});
  endtask

  // NRZI: a 0 toggles the line, a 1 holds it.
  task automatic raw(input logic b, input logic bv, input logic ps, input logic er);
    if (!b) lvl = ~lvl;
    push(lvl ? SJ : SK, bv, ps, 1'b0, er);
  endtask

  task automatic idle(input int n);
    act = 1'b0;
    lvl = 1'b1;
    repeat (n) push(SJ, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sync_seq();
    act = 1'b0;
    repeat (7) raw(1'b0, 1'b0, 1'b0, 1'b0);
    act = 1'b1;
    raw(1'b1, 1'b0, 1'b1, 1'b0);
    run = 1;
  endtask

  task automatic dbit(input logic b, input logic bv);
    raw(b, bv, 1'b0, 1'b0);
    run = b ? run + 1 : 0;
    if (run == 6) begin
      raw(1'b0, 1'b0, 1'b0, 1'b0);
      run = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) ebo = v;
      dbit(v[i], i == 7);
    end
  endtask

  task automatic eop(input logic mis);
    act = 1'b1;
    push(S0, 1'b0, 1'b0, 1'b0, mis);
    push(S0, 1'b0, 1'b0, 1'b0, 1'b0);
    act = 1'b0;
    lvl = 1'b1;
    push(SJ, 1'b0, 1'b0, ~mis, 1'b0);
  endtask

  task automatic play();
    obs_q.delete();
    foreach (sym_q[i]) begin
      {dp, dm} = sym_q[i];
      @(posedge clk);
      #1;
      obs_q.push_back(outs_now());
    end
    sym_q.delete();
  endtask

  task automatic test_reset();
    rst_L = 1'b0;
    {dp, dm} = SJ;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (outs_now() !== 13'd0) begin
      bad++;
      $display("FAIL reset_state got %h want 0000", outs_now());
    end
    rst_L = 1'b1;
  endtask

  task automatic test_clean();
    idle(3); sync_seq(); send_byte(8'hA5); eop(1'b0); idle(2);
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL clean_pkt sample %0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_stuffing();
    idle(2); sync_seq(); send_byte(8'hFF); send_byte(8'h00); eop(1'b0); idle(2);
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL stuffing sample %0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_stuff_err();
    logic [15:0] early;
    early = {SK, SJ, SK, SJ, SK, SJ, SK, SK};
    idle(2); sync_seq();
    repeat (5) raw(1'b1, 1'b0, 1'b0, 1'b0);
    act = 1'b0;
    raw(1'b1, 1'b0, 1'b0, 1'b1);
    // Six J are one short of leaving ABORT, so this SYNC must be ignored.
    idle(6);
    for (int i = 7; i >= 0; i--) push(early[i*2 +: 2], 1'b0, 1'b0, 1'b0, 1'b0);
    push(S0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(S0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(7); sync_seq(); send_byte(8'($urandom)); eop(1'b0); idle(2);
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL stuff_err sample %0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_misaligned();
    idle(2); sync_seq(); send_byte(8'($urandom));
    repeat (4) dbit(1'($urandom_range(0, 1)), 1'b0);
    eop(1'b1); idle(2);
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL misaligned_eop sample %0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_short_sync();
    logic [7:0] d;
    d = 8'hA5;
    idle(3);
    raw(1'b0, 1'b0, 1'b0, 1'b0); raw(1'b0, 1'b0, 1'b0, 1'b0);
    raw(1'b0, 1'b0, 1'b0, 1'b0); raw(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) raw(d[i], 1'b0, 1'b0, 1'b0);
    push(S0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(S0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL short_sync sample %0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    repeat (16) begin
      idle($urandom_range(1, 4));
      sync_seq();
      repeat ($urandom_range(1, 4)) send_byte(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 7)) dbit(1'($urandom_range(0, 1)), 1'b0);
        eop(1'b1);
      end else begin
        eop(1'b0);
      end
    end
    idle(2);
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL random_pkts sample %0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midbyte();
    idle(2); sync_seq();
    repeat (4) dbit(1'($urandom_range(0, 1)), 1'b0);
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL pre_reset sample %0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    rst_L = 1'b0;
    #1;
    total++;
    if (outs_now() !== 13'd0) begin
      bad++;
      $display("FAIL reset_async got %h want 0000", outs_now());
    end
    repeat (5) begin
      {dp, dm} = 2'($urandom);
      @(posedge clk);
      #1;
      total++;
      if (outs_now() !== 13'd0) begin
        bad++;
        $display("FAIL reset_hold got %h want 0000", outs_now());
      end
    end
    rst_L = 1'b1;
    lvl = 1'b1; act = 1'b0; ebo = 8'd0; run = 0;
    // Activity without a full SYNC must not open a packet.
    push(SK, 1'b0, 1'b0, 1'b0, 1'b0); push(SK, 1'b0, 1'b0, 1'b0, 1'b0);
    push(SJ, 1'b0, 1'b0, 1'b0, 1'b0); push(SJ, 1'b0, 1'b0, 1'b0, 1'b0);
    push(SK, 1'b0, 1'b0, 1'b0, 1'b0); push(SK, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3); sync_seq();
    send_byte(8'($urandom)); send_byte(8'($urandom));
    eop(1'b0); idle(2);
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL post_reset sample %0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_clean();
    test_stuffing();
    test_stuff_err();
    test_misaligned();
    test_short_sync();
    test_random();
    test_reset_midbyte();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
